dac_wave_sched: RTL
===================

# dac_wave_sched

Two-channel waveform scheduler that sources sample streams for the AD56x3 DAC driver. Paced by a programmable sample-rate tick, it generates sawtooth or triangle codes per channel. It presents them on two Avalon-ST source ports that connect directly to the driver's sink ports. It is configured through a small Avalon-MM register slave and flags samples the driver failed to consume in time.

## Interface
Parameters:
- DATA_WIDTH, 14, sample width; matches the driver's DATA_WIDTH.
- SIGN_0, "UNSIGNED", channel 0 output coding: "UNSIGNED" (offset binary) or "SIGNED" (two's complement).
- SIGN_1, "UNSIGNED", channel 1 output coding, same encoding as SIGN_0.

Ports:
- One clock; reset is synchronous and active-low.
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- avsAdr  in  3  register address.
- avsWr  in  1  write strobe.
- avsWrData  in  16  write data.
- avsRd  in  1  read strobe.
- avsRdData  out  16  read data, registered.
- asoValid0 / asoValid1  out  1  sample valid, channels 0 and 1.
- asoData0 / asoData1  out  DATA_WIDTH  sample code, channels 0 and 1.
- asoRdy0 / asoRdy1  in  1  sink ready, channels 0 and 1.

## Operation
- Register map (16-bit):
  - 0 CTRL: [0] en0, [1] en1, [2] tri0, [3] tri1; tri=0 selects sawtooth, tri=1 selects triangle.
  - 1 PERIOD: sample period minus 1, in clk cycles.
  - 2 STEP0: signed step for channel 0.
  - 3 STEP1: signed step for channel 1.
  - 4 STATUS: [0] ovr0, [1] ovr1; sticky; write 1 to clear.
  - 5–7: reserved; read 0, writes ignored.
- Tick counter:
  - Counts 0..PERIOD and raises a 1-cycle tick when the count equals PERIOD, then returns to 0.
  - PERIOD=0 ticks every cycle.
  - A write to PERIOD zeroes the counter.
- Per-channel FSM:
  - IDLE (en=0): accumulator acc=0, direction up.
  - IDLE→WAIT on en=1.
  - WAIT→PEND on tick: load data=code(acc), assert valid, update acc.
  - PEND→WAIT on valid&&rdy.
  - Tick in the same cycle as valid&&rdy reloads the next sample: stays in PEND, no overrun.
  - Tick in PEND without rdy: set ovr, hold data, do not advance acc.
  - en cleared in PEND: hold valid until accepted, then go to IDLE. en cleared in WAIT: go to IDLE immediately.
- Sawtooth: acc ← (acc + STEP[DATA_WIDTH-1:0]) mod 2^DATA_WIDTH. Negative steps wrap downward.
- Triangle arithmetic:
  - |STEP| is computed in 17 bits and saturated to MAX = 2^DATA_WIDTH−1.
  - Direction up: if acc+|STEP| ≥ MAX, set acc=MAX and flip direction; otherwise add.
  - Direction down: if acc ≤ |STEP|, set acc=0 and flip direction; otherwise subtract.
  - STEP=0 holds acc constant.
- Output coding: code(acc)=acc for "UNSIGNED"; for "SIGNED", acc with the MSB inverted.
- Changing a tri bit while enabled takes effect at the next update; direction keeps its current value.
- Reset mid-operation: every state returns to its reset value on the next edge. An in-flight sample is dropped.

## Timing
- Reset values:
  - avsRdData=0, asoValid0/1=0, asoData0/1=0.
  - All registers 0; STATUS=0; counter 0; acc 0; direction up; FSMs IDLE.
- Sample path: tick at cycle t → valid and data at cycle t+1.
- Read path: read latency 1; avsRdData is valid the cycle after avsRd. A write and a hardware ovr set in the same cycle: the set wins.
- Register writes take effect the cycle after avsWr.
- Data is stable while valid=1 and rdy=0.

## Structure
- Package dac_wave_pkg holds:
  - register address constants;
  - CTRL and STATUS bit indices;
  - the channel state enum (IDLE, WAIT, PEND).
- Sub-module dac_wave_chan implements the per-channel FSM, accumulator, triangle/saw arithmetic and output coding. It has a SIGN parameter and is instantiated twice.
- The top level holds the register file, tick counter and STATUS logic.

## Test plan
- Reset: hold reset=0 for 10 cycles → all outputs 0; reads of registers 0–7 return 0.
- Sawtooth up: PERIOD=3, STEP0=100, CTRL=0x1, asoRdy0=1 → 1-cycle valid every 4 cycles carrying data 0, 100, 200, 300.
- Sawtooth down-wrap: STEP0=−2, CTRL=0x1 → data 0, 16382, 16380.
- Triangle: STEP1=5000, CTRL=0xA, PERIOD=0, asoRdy1=1 → data 0, 5000, 10000, 15000, 16383, 11383, 6383, 1383, 0, 5000.
- Backpressure: PERIOD=3, STEP0=100, asoRdy0=0 for 12 cycles:
  - valid stays high with data 0 and STATUS reads 0x1;
  - after rdy returns, the next sample is 100;
  - writing 1 to STATUS clears it to 0.
- Signed coding with reset mid-run: SIGN_1="SIGNED", CTRL=0x2 → first data 0x2000; assert reset during PEND → valid=0 and data=0 on the next edge.

Source files
------------

// File: rtl/dac_wave_pkg.sv
// Shared register map, bit positions and channel state type for the
// two-channel DAC waveform scheduler.
package dac_wave_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_STEP0  = 3'd2;
    localparam logic [2:0] ADDR_STEP1  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    localparam int CTRL_EN0    = 0;
    localparam int CTRL_EN1    = 1;
    localparam int CTRL_TRI0   = 2;
    localparam int CTRL_TRI1   = 3;

    localparam int STATUS_OVR0 = 0;
    localparam int STATUS_OVR1 = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PEND = 2'd2
    } chanState_t;

endpackage

// File: rtl/dac_wave_chan.sv
// One waveform channel: sample-handshake FSM, sawtooth/triangle accumulator
// and output coding for an Avalon-ST source.
module dac_wave_chan
    import dac_wave_pkg::*;
#(
    parameter int    DATA_WIDTH = 14,
    parameter string SIGN       = "UNSIGNED"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  triMode,
    input  logic [15:0]           step,
    input  logic                  tick,
    input  logic                  rdy,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  ovrSet
);

    localparam logic [DATA_WIDTH-1:0] MAX       = '1;
    localparam bit                    IS_SIGNED = (SIGN == "SIGNED");

    chanState_t            state;
    logic [DATA_WIDTH-1:0] acc;
    logic                  dirDown;

    logic [16:0]           stepMag;
    logic [DATA_WIDTH-1:0] magSat;
    logic [DATA_WIDTH:0]   upSum;
    logic [DATA_WIDTH-1:0] accNext;
    logic                  dirNext;
    logic [DATA_WIDTH-1:0] code;

    // Magnitude needs 17 bits so that -32768 does not overflow before saturation.
    always_comb begin
        stepMag = step[15] ? (17'd0 - {step[15], step}) : {1'b0, step};
        magSat  = (stepMag > 17'(MAX)) ? MAX : stepMag[DATA_WIDTH-1:0];
        upSum   = {1'b0, acc} + {1'b0, magSat};
        accNext = acc + step[DATA_WIDTH-1:0];
        dirNext = dirDown;
        if (triMode) begin
            if (!dirDown) begin
                if (upSum >= {1'b0, MAX}) begin
                    accNext = MAX;
                    dirNext = 1'b1;
                end else begin
                    accNext = upSum[DATA_WIDTH-1:0];
                end
            end else begin
                if (acc <= magSat) begin
                    accNext = '0;
                    dirNext = 1'b0;
                end else begin
                    accNext = acc - magSat;
                end
            end
        end
    end

    assign code   = IS_SIGNED ? {~acc[DATA_WIDTH-1], acc[DATA_WIDTH-2:0]} : acc;
    assign ovrSet = (state == PEND) && tick && !rdy;

    // NOTE: all state updates here are non-blocking so every branch sees the
    // pre-edge acc/dirDown, which is what the combinational next-value logic uses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            dirDown <= 1'b0;
            valid   <= 1'b0;
            data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    acc     <= '0;
                    dirDown <= 1'b0;
                    if (en) state <= WAIT;
                end
                WAIT: begin
                    if (!en) begin
                        state   <= IDLE;
                        acc     <= '0;
                        dirDown <= 1'b0;
                    end else if (tick) begin
                        data    <= code;
                        valid   <= 1'b1;
                        acc     <= accNext;
                        dirDown <= dirNext;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    // A tick without rdy leaves the held sample and acc untouched.
                    if (rdy) begin
                        if (en && tick) begin
                            data    <= code;
                            acc     <= accNext;
                            dirDown <= dirNext;
                        end else begin
                            valid <= 1'b0;
                            if (en) begin
                                state <= WAIT;
                            end else begin
                                state   <= IDLE;
                                acc     <= '0;
                                dirDown <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dac_wave_sched.sv
// Two-channel waveform scheduler: register slave, sample-rate tick counter
// and sticky overrun status around two dac_wave_chan instances.
module dac_wave_sched
    import dac_wave_pkg::*;
#(
    parameter int    DATA_WIDTH = 14,
    parameter string SIGN_0     = "UNSIGNED",
    parameter string SIGN_1     = "UNSIGNED"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            avsAdr,
    input  logic                  avsWr,
    input  logic [15:0]           avsWrData,
    input  logic                  avsRd,
    output logic [15:0]           avsRdData,
    output logic                  asoValid0,
    output logic [DATA_WIDTH-1:0] asoData0,
    input  logic                  asoRdy0,
    output logic                  asoValid1,
    output logic [DATA_WIDTH-1:0] asoData1,
    input  logic                  asoRdy1
);

    logic [3:0]  ctrl;
    logic [15:0] period;
    logic [15:0] step0;
    logic [15:0] step1;
    logic [1:0]  status;
    logic [15:0] tickCnt;
    logic        tick;
    logic [1:0]  ovrSet;
    logic [1:0]  clrMask;
    logic [15:0] rdMux;

    assign tick    = (tickCnt == period);
    assign clrMask = (avsWr && avsAdr == ADDR_STATUS) ? avsWrData[1:0] : 2'b00;

    always_comb begin
        rdMux = '0;
        case (avsAdr)
            ADDR_CTRL:   rdMux = {12'd0, ctrl};
            ADDR_PERIOD: rdMux = period;
            ADDR_STEP0:  rdMux = step0;
            ADDR_STEP1:  rdMux = step1;
            ADDR_STATUS: rdMux = {14'd0, status};
            default:     rdMux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl      <= '0;
            period    <= '0;
            step0     <= '0;
            step1     <= '0;
            status    <= '0;
            tickCnt   <= '0;
            avsRdData <= '0;
        end else begin
            if (avsRd) avsRdData <= rdMux;

            if (avsWr) begin
                case (avsAdr)
                    ADDR_CTRL:   ctrl   <= avsWrData[3:0];
                    ADDR_PERIOD: period <= avsWrData;
                    ADDR_STEP0:  step0  <= avsWrData;
                    ADDR_STEP1:  step1  <= avsWrData;
                    default:     ;
                endcase
            end

            if ((avsWr && avsAdr == ADDR_PERIOD) || tick) tickCnt <= '0;
            else                                          tickCnt <= tickCnt + 16'd1;

            // Hardware set is OR-ed in after the clear so a coincident overrun survives.
            status <= (status & ~clrMask) | ovrSet;
        end
    end

    dac_wave_chan #(.DATA_WIDTH(DATA_WIDTH), .SIGN(SIGN_0)) u_chan0 (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl[CTRL_EN0]),
        .triMode (ctrl[CTRL_TRI0]),
        .step    (step0),
        .tick    (tick),
        .rdy     (asoRdy0),
        .valid   (asoValid0),
        .data    (asoData0),
        .ovrSet  (ovrSet[STATUS_OVR0])
    );

    dac_wave_chan #(.DATA_WIDTH(DATA_WIDTH), .SIGN(SIGN_1)) u_chan1 (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl[CTRL_EN1]),
        .triMode (ctrl[CTRL_TRI1]),
        .step    (step1),
        .tick    (tick),
        .rdy     (asoRdy1),
        .valid   (asoValid1),
        .data    (asoData1),
        .ovrSet  (ovrSet[STATUS_OVR1])
    );

endmodule
